// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-flag positions within the packed {N, Z}
// status view, and the active level of the status register reset.
`timescale 1ns/1ps
package cpu_pkg;

  localparam logic FLAG_Z = 1'b0;
  localparam logic FLAG_N = 1'b1;

  localparam logic STATUS_RESET_ACTIVE = 1'b0;

endpackage

// File: rtl/status_flags.sv
// Status register holding the ALU zero (Z) and negative (N) condition flags
// for the control unit's conditional branches; loads both flags together.
`timescale 1ns/1ps
module status_flags
  import cpu_pkg::*;
(
  input  logic clock,
  input  logic status_reset,
  input  logic status_wr,
  input  logic zero_indicator_in,
  input  logic signal_bit_in,
  output logic flag_Z,
  output logic flag_N
);

  // Packed {N, Z} so the bit positions match the control-unit decode.
  logic [1:0] flags_reg;

  always_ff @(posedge clock or negedge status_reset) begin
    if (status_reset == STATUS_RESET_ACTIVE) begin
      flags_reg <= '0;
    end else if (status_wr) begin
      flags_reg[FLAG_Z] <= zero_indicator_in;
      flags_reg[FLAG_N] <= signal_bit_in;
    end
  end

  assign flag_Z = flags_reg[FLAG_Z];
  assign flag_N = flags_reg[FLAG_N];

endmodule

// File: tb/tb_status_flags.sv
// Self-checking bench for status_flags: directed cases followed by random
// writes, holds and asynchronous resets, compared against a two-flag model.
`timescale 1ns/1ps

module clock_generator (
  output logic clock
);
  initial clock = 1'b0;
  always #1 clock = ~clock;
endmodule

module tb_status_flags;

  logic clock;
  logic status_reset;
  logic status_wr;
  logic zero_indicator_in;
  logic signal_bit_in;
  logic flag_Z;
  logic flag_N;

  int checks = 0;
  int errors = 0;

  // Model of the stored flags, kept as {N, Z}.
  logic [1:0] exp_flags;

  clock_generator u_clk (.clock(clock));

  status_flags dut (
    .clock             (clock),
    .status_reset      (status_reset),
    .status_wr         (status_wr),
    .zero_indicator_in (zero_indicator_in),
    .signal_bit_in     (signal_bit_in),
    .flag_Z            (flag_Z),
    .flag_N            (flag_N)
  );

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {N,Z}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies inputs at a falling edge, lets one rising edge pass, then compares.
  task automatic step(input logic rst_v, input logic wr, input logic z, input logic n,
                      input string tag);
    status_reset      = rst_v;
    status_wr         = wr;
    zero_indicator_in = z;
    signal_bit_in     = n;
    @(posedge clock);
    if (!rst_v)  exp_flags = 2'b00;
    else if (wr) exp_flags = {n, z};
    @(negedge clock);
    check(tag, {flag_N, flag_Z}, exp_flags);
    $display("step %-16s rst=%b wr=%b z=%b n=%b -> N=%b Z=%b", tag, rst_v, wr, z, n,
             flag_N, flag_Z);
  endtask

  // Flags must hold across an edge where no write was enabled.
  property p_hold;
    @(negedge clock) (status_reset && $past(status_reset) && !status_wr)
      |-> ({flag_N, flag_Z} == $past({flag_N, flag_Z}));
  endproperty
  a_hold: assert property (p_hold) else $error("FAIL sva_hold: flags changed without write");

  // Reset falling must clear the flags without waiting for a clock.
  always @(negedge status_reset) begin
    #0.1;
    a_async_clear: assert (flag_Z == 1'b0 && flag_N == 1'b0)
      else $error("FAIL sva_async_reset: N=%b Z=%b", flag_N, flag_Z);
  end

  initial begin
    exp_flags         = 2'b00;
    status_reset      = 1'b0;
    status_wr         = 1'b1;
    zero_indicator_in = 1'b1;
    signal_bit_in     = 1'b1;
    #0.5;
    check("reset_immediate", {flag_N, flag_Z}, 2'b00);
    @(negedge clock);
    step(1'b0, 1'b1, 1'b1, 1'b1, "reset_edge0");
    step(1'b0, 1'b1, 1'b1, 1'b1, "reset_edge1");

    step(1'b1, 1'b1, 1'b0, 1'b1, "write_negative");
    step(1'b1, 1'b1, 1'b1, 1'b0, "write_zero");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, "hold");
    step(1'b1, 1'b1, 1'b0, 1'b0, "write_positive");
    step(1'b1, 1'b0, 1'b1, 1'b1, "hold_positive");
    step(1'b1, 1'b1, 1'b1, 1'b1, "write_both");
    step(1'b1, 1'b1, 1'b1, 1'b0, "write_zero2");

    // Write pulse entirely between rising edges must not load.
    status_wr = 1'b0; zero_indicator_in = 1'b0; signal_bit_in = 1'b1;
    #0.2 status_wr = 1'b1;
    #0.5 status_wr = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("short_pulse", {flag_N, flag_Z}, exp_flags);

    // Asynchronous reset between edges, flags at Z=1 N=0.
    #0.4;
    status_reset = 1'b0;
    #0.2;
    exp_flags = 2'b00;
    check("async_mid_cycle", {flag_N, flag_Z}, exp_flags);
    @(negedge clock);
    check("async_held", {flag_N, flag_Z}, exp_flags);
    step(1'b1, 1'b0, 1'b1, 1'b1, "release_no_write");
    step(1'b1, 1'b0, 1'b0, 1'b1, "release_hold");

    // Random writes, holds and occasional mid-cycle resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(15) == 0) begin
        status_wr         = 1'($urandom_range(1));
        zero_indicator_in = 1'($urandom_range(1));
        signal_bit_in     = 1'($urandom_range(1));
        #0.3;
        status_reset = 1'b0;
        #0.2;
        exp_flags = 2'b00;
        check("rand_async", {flag_N, flag_Z}, exp_flags);
        @(negedge clock);
        check("rand_async_edge", {flag_N, flag_Z}, exp_flags);
        $display("rand %0d async reset -> N=%b Z=%b", i, flag_N, flag_Z);
      end else begin
        step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
             "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
